uart_io_bridge: RTL and testbench

- Sits downstream of the core-side MMU's byte I/O ports (io_in_*/io_out_*/io_err).
- Converts them into AXI4-Lite master accesses to an AXI UART Lite peripheral (RX FIFO +0x0, TX FIFO +0x4, STAT +0x8, CTRL +0xC).
- Buffers received bytes in a local RX FIFO and holds one pending TX byte.
- Polls the status register and reports line errors as sticky bits.

---
 rtl/uart_io_bridge.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_io_bridge.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_io_bridge.sv
// uart_io_bridge: MMU byte I/O to AXI4-Lite UART Lite master.
// Polls STAT, moves RX bytes into a local FIFO, sends one TX byte.
module uart_io_bridge #(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int          RX_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [7:0]  io_in_data,
  output logic        io_in_vld,
  input  logic        io_in_rdy,
  input  logic [7:0]  io_out_data,
  input  logic        io_out_vld,
  output logic        io_out_rdy,
  output logic [4:0]  io_err,
  input  logic        err_clr,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready
);

  localparam int AW = RX_DEPTH_LOG2;

  typedef enum logic [3:0] {
    INIT, INIT_W, INIT_B, IDLE,
    STAT_AR, STAT_R, DECIDE,
    RX_AR, RX_R, TX_W, TX_B
  } state_t;

  state_t      state, state_n;
  logic [7:0]  stat, stat_n;
  logic [7:0]  tx_data;
  logic        tx_pend, tx_pend_n;
  logic        out_rdy_n;
  logic [4:0]  err_n;
  logic        arvalid_n, rready_n;
  logic        awvalid_n, wvalid_n, bready_n;
  logic [31:0] araddr_n, awaddr_n, wdata_n;
  logic        cap, push, pop;

  logic [7:0]  mem [2**AW];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty;

  logic unused_ok;
  assign unused_ok = ^{m_axi_rdata[31:8], m_axi_rresp[0],
                       m_axi_bresp[0], stat[7:4], stat[2]};

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign io_in_vld   = !empty;
  assign io_in_data  = mem[rd_ptr[AW-1:0]];
  assign pop         = io_in_vld && io_in_rdy;
  assign cap         = io_out_vld && io_out_rdy;
  assign m_axi_wstrb = m_axi_wvalid ? 4'b0001 : 4'b0000;

  // Next-state, AXI channel and error/TX flag computation.
  always_comb begin
    state_n   = state;
    stat_n    = stat;
    tx_pend_n = tx_pend;
    out_rdy_n = io_out_rdy;
    err_n     = io_err;
    arvalid_n = m_axi_arvalid;
    araddr_n  = m_axi_araddr;
    rready_n  = m_axi_rready;
    awvalid_n = m_axi_awvalid;
    awaddr_n  = m_axi_awaddr;
    wvalid_n  = m_axi_wvalid;
    wdata_n   = m_axi_wdata;
    bready_n  = m_axi_bready;
    push      = 1'b0;

    if (cap) begin
      tx_pend_n = 1'b1;
      out_rdy_n = 1'b0;
    end

    unique case (state)
      INIT: begin
        awvalid_n = 1'b1;
        wvalid_n  = 1'b1;
        awaddr_n  = BASE_ADDR + 32'hC;
        wdata_n   = 32'h3;
        state_n   = INIT_W;
      end
      INIT_W, TX_W: begin
        awvalid_n = m_axi_awvalid && !m_axi_awready;
        wvalid_n  = m_axi_wvalid && !m_axi_wready;
        if (!awvalid_n && !wvalid_n) begin
          bready_n = 1'b1;
          state_n  = (state == INIT_W) ? INIT_B : TX_B;
        end
      end
      INIT_B: begin
        if (m_axi_bvalid) begin
          bready_n  = 1'b0;
          out_rdy_n = 1'b1;
          state_n   = IDLE;
        end
      end
      IDLE: begin
        arvalid_n = 1'b1;
        araddr_n  = BASE_ADDR + 32'h8;
        state_n   = STAT_AR;
      end
      STAT_AR, RX_AR: begin
        if (m_axi_arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = (state == STAT_AR) ? STAT_R : RX_R;
        end
      end
      STAT_R: begin
        if (m_axi_rvalid) begin
          rready_n   = 1'b0;
          stat_n     = m_axi_rdata[7:0];
          err_n[3:1] = err_n[3:1] | m_axi_rdata[7:5];
          if (m_axi_rresp[1]) begin
            err_n[4] = 1'b1;
            state_n  = IDLE;
          end else begin
            state_n  = DECIDE;
          end
        end
      end
      DECIDE: begin
        if (stat[1] && full) err_n[0] = 1'b1;
        if (stat[0] && !full) begin
          arvalid_n = 1'b1;
          araddr_n  = BASE_ADDR;
          state_n   = RX_AR;
        end else if (tx_pend && !stat[3]) begin
          awvalid_n = 1'b1;
          wvalid_n  = 1'b1;
          awaddr_n  = BASE_ADDR + 32'h4;
          wdata_n   = {24'h0, tx_data};
          state_n   = TX_W;
        end else begin
          state_n   = IDLE;
        end
      end
      RX_R: begin
        if (m_axi_rvalid) begin
          rready_n = 1'b0;
          if (m_axi_rresp[1]) err_n[4] = 1'b1;
          else push = 1'b1;
          state_n  = IDLE;
        end
      end
      TX_B: begin
        if (m_axi_bvalid) begin
          bready_n  = 1'b0;
          tx_pend_n = 1'b0;
          out_rdy_n = 1'b1;
          if (m_axi_bresp[1]) err_n[4] = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = INIT;
    endcase

    if (err_clr) err_n = '0;
  end

  // Control and AXI output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= INIT;
      stat          <= '0;
      tx_pend       <= 1'b0;
      tx_data       <= '0;
      io_out_rdy    <= 1'b0;
      io_err        <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_rready  <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_bready  <= 1'b0;
    end else begin
      state         <= state_n;
      stat          <= stat_n;
      tx_pend       <= tx_pend_n;
      io_out_rdy    <= out_rdy_n;
      io_err        <= err_n;
      m_axi_arvalid <= arvalid_n;
      m_axi_araddr  <= araddr_n;
      m_axi_rready  <= rready_n;
      m_axi_awvalid <= awvalid_n;
      m_axi_awaddr  <= awaddr_n;
      m_axi_wvalid  <= wvalid_n;
      m_axi_wdata   <= wdata_n;
      m_axi_bready  <= bready_n;
      if (cap) tx_data <= io_out_data;
    end
  end

  // RX FIFO pointers; extra MSB separates full from empty.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // RX FIFO storage.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= m_axi_rdata[7:0];
  end

endmodule

// File: tb/tb_uart_io_bridge.sv
// tb_uart_io_bridge: scoreboard bench with a UART Lite AXI model.
// Expected writes and RX bytes are queued at stimulus time.
module tb_uart_io_bridge;

  localparam logic [31:0] BASE = 32'h4060_0000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  io_in_data;
  logic        io_in_vld;
  logic        io_in_rdy = 1'b0;
  logic [7:0]  io_out_data = 8'h0;
  logic        io_out_vld = 1'b0;
  logic        io_out_rdy;
  logic [4:0]  io_err;
  logic        err_clr = 1'b0;
  logic [31:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b1;
  logic [31:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = '0;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b1;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b1;
  logic [1:0]  m_axi_bresp = '0;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_wr[$];
  logic [7:0]  exp_rx[$];
  logic [8:0]  rx_src[$];

  logic [7:0]  stat_cfg = 8'h00;
  logic [1:0]  bresp_cfg = 2'b00;
  logic        r_pend = 0, r_drop = 0;
  logic        b_pend = 0, b_drop = 0;
  logic [31:0] r_addr = '0;
  logic        ar_seen = 0;
  logic [31:0] first_ar = '0;
  int          n_wr = 0, n_b = 0, rx_reads = 0;

  uart_io_bridge #(
    .BASE_ADDR(BASE),
    .RX_DEPTH_LOG2(4)
  ) dut (
    .clk(clk), .rstn(rstn),
    .io_in_data(io_in_data), .io_in_vld(io_in_vld),
    .io_in_rdy(io_in_rdy),
    .io_out_data(io_out_data), .io_out_vld(io_out_vld),
    .io_out_rdy(io_out_rdy),
    .io_err(io_err), .err_clr(err_clr),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // UART Lite slave model plus write-channel scoreboard.
  always @(negedge clk) begin
    logic [8:0]  e;
    logic [63:0] w;
    if (!rstn) begin
      m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0;
      m_axi_bvalid = 0; m_axi_bresp = '0;
      r_pend = 0; r_drop = 0; b_pend = 0; b_drop = 0;
    end else begin
      if (r_drop) begin m_axi_rvalid = 0; r_drop = 0; end
      if (b_drop) begin m_axi_bvalid = 0; b_drop = 0; end
      if (r_pend) begin
        r_pend = 0;
        m_axi_rvalid = 1;
        m_axi_rresp = 2'b00;
        m_axi_rdata = '0;
        if (r_addr == BASE + 32'h8) begin
          m_axi_rdata = {24'h0,
            stat_cfg | {7'h0, rx_src.size() != 0}};
        end else if (r_addr == BASE) begin
          rx_reads++;
          if (rx_src.size() != 0) begin
            e = rx_src.pop_front();
            m_axi_rdata = {24'h0, e[7:0]};
            m_axi_rresp = e[8] ? 2'b10 : 2'b00;
          end
        end else begin
          m_axi_rresp = 2'b10;
        end
      end
      if (b_pend) begin
        b_pend = 0;
        m_axi_bvalid = 1;
        m_axi_bresp = bresp_cfg;
      end
      if (m_axi_rvalid && m_axi_rready) r_drop = 1;
      if (m_axi_bvalid && m_axi_bready) begin
        b_drop = 1;
        n_b++;
      end
      if (m_axi_arvalid) begin
        r_pend = 1;
        r_addr = m_axi_araddr;
        if (!ar_seen) begin
          ar_seen = 1;
          first_ar = m_axi_araddr;
        end
      end
      if (m_axi_awvalid || m_axi_wvalid) begin
        n_wr++;
        b_pend = 1;
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexp addr=%h data=%h",
                   m_axi_awaddr, m_axi_wdata);
        end else begin
          w = exp_wr.pop_front();
          chk("wr_addr", m_axi_awaddr, w[63:32]);
          chk("wr_data", m_axi_wdata, w[31:0]);
          chk("wr_strb", {m_axi_awvalid, m_axi_wvalid,
                          m_axi_wstrb}, 32'h31);
        end
      end
    end
  end

  // RX byte scoreboard: compares every byte the MMU side pops.
  always @(negedge clk) begin
    logic [7:0] b;
    if (rstn && io_in_vld && io_in_rdy) begin
      if (exp_rx.size() == 0) begin
        checks++; errors++;
        $display("FAIL rx_unexp act=%h", io_in_data);
      end else begin
        b = exp_rx.pop_front();
        chk("rx_byte", io_in_data, b);
      end
    end
  end

  task automatic send_tx(input logic [7:0] b);
    exp_wr.push_back({BASE + 32'h4, 24'h0, b});
    for (int i = 0; i < 200 && !io_out_rdy; i++) @(negedge clk);
    chk("tx_rdy_wait", io_out_rdy, 1);
    @(posedge clk); #1;
    io_out_vld = 1; io_out_data = b;
    @(posedge clk); #1;
    io_out_vld = 0;
    chk("tx_rdy_low", io_out_rdy, 0);
  endtask

  task automatic pulse_rdy();
    @(posedge clk); #1 io_in_rdy = 1;
    @(posedge clk); #1 io_in_rdy = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    int w0, nb0, r0;
    idle(3);
    chk("rst_ctl", {m_axi_arvalid, m_axi_rready, m_axi_awvalid,
                    m_axi_wvalid, m_axi_bready, io_in_vld,
                    io_out_rdy}, 0);
    chk("rst_err", io_err, 0);
    chk("rst_addr", m_axi_araddr | m_axi_awaddr | m_axi_wdata, 0);

    exp_wr.push_back({BASE + 32'hC, 32'h3});
    @(posedge clk); #1 rstn = 1;
    for (int i = 0; i < 50 && !io_out_rdy; i++) @(negedge clk);
    chk("init_rdy", io_out_rdy, 1);
    chk("init_nwr", n_wr, 1);
    idle(3);
    chk("first_ar", first_ar, BASE + 32'h8);

    rx_src.push_back({1'b0, 8'h41});
    exp_rx.push_back(8'h41);
    for (int i = 0; i < 100 && !io_in_vld; i++) @(negedge clk);
    chk("rx_vld", io_in_vld, 1);
    chk("rx_head", io_in_data, 8'h41);
    pulse_rdy();
    @(negedge clk);
    chk("rx_empty", io_in_vld, 0);

    stat_cfg = 8'h04;
    w0 = n_wr; nb0 = n_b;
    send_tx(8'h5A);
    for (int i = 0; i < 100 && !io_out_rdy; i++) @(negedge clk);
    chk("tx_rdy_back", io_out_rdy, 1);
    chk("tx_nwr", n_wr, w0 + 1);
    chk("tx_b_first", n_b, nb0 + 1);

    stat_cfg = 8'h08;
    w0 = n_wr; r0 = rx_reads;
    send_tx(8'hC3);
    rx_src.push_back({1'b0, 8'h77});
    exp_rx.push_back(8'h77);
    idle(80);
    chk("txfull_nwr", n_wr, w0);
    chk("txfull_rxrd", rx_reads, r0 + 1);
    chk("txfull_vld", io_in_vld, 1);
    chk("txfull_rdy", io_out_rdy, 0);
    stat_cfg = 8'h04;
    for (int i = 0; i < 100 && !io_out_rdy; i++) @(negedge clk);
    chk("txgo_nwr", n_wr, w0 + 1);
    chk("txgo_rdy", io_out_rdy, 1);
    pulse_rdy();
    @(negedge clk);
    chk("txgo_rxempty", io_in_vld, 0);

    stat_cfg = 8'h02;
    r0 = rx_reads;
    for (int i = 0; i < 17; i++) begin
      rx_src.push_back({1'b0, 8'h80 + 8'(i)});
      exp_rx.push_back(8'h80 + 8'(i));
    end
    idle(400);
    chk("fill_rxrd", rx_reads, r0 + 16);
    chk("fill_lost", io_err, 5'b00001);
    pulse_rdy();
    for (int i = 0; i < 100 && rx_reads != r0 + 17; i++)
      @(negedge clk);
    chk("fill_refill", rx_reads, r0 + 17);
    stat_cfg = 8'h00;
    idle(40);
    @(posedge clk); #1 err_clr = 1;
    @(posedge clk); #1 err_clr = 0;
    @(negedge clk);
    chk("err_clr", io_err, 0);
    @(posedge clk); #1 io_in_rdy = 1;
    idle(20);
    @(posedge clk); #1 io_in_rdy = 0;
    @(negedge clk);
    chk("drain_vld", io_in_vld, 0);
    chk("drain_q", exp_rx.size(), 0);

    stat_cfg = 8'hE0;
    idle(30);
    chk("line_err", io_err, 5'b01110);
    stat_cfg = 8'h00;
    r0 = rx_reads;
    rx_src.push_back({1'b1, 8'h99});
    for (int i = 0; i < 100 && rx_reads == r0; i++)
      @(negedge clk);
    idle(10);
    chk("resp_err", io_err, 5'b11110);
    chk("resp_cnt", io_in_vld, 0);
    chk("wr_q_done", exp_wr.size(), 0);

    rx_src.push_back({1'b0, 8'h55});
    exp_rx.push_back(8'h55);
    for (int i = 0; i < 100 && !io_in_vld; i++) @(negedge clk);
    chk("mid_vld", io_in_vld, 1);
    stat_cfg = 8'h08;
    idle(3);
    @(posedge clk); #1 rstn = 0;
    exp_rx.delete();
    exp_wr.delete();
    rx_src.delete();
    @(negedge clk);
    chk("mid_rst_ctl", {m_axi_arvalid, m_axi_rready,
                        m_axi_awvalid, m_axi_wvalid,
                        m_axi_bready, io_in_vld,
                        io_out_rdy}, 0);
    chk("mid_rst_err", io_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
